wide_add_sequencer: RTL

- Multi-cycle controller that performs wide add/subtract by sequencing one shared 16-bit add slice over WORDS operand words, least-significant word first.
- The carry is chained between cycles.
- Used where a full-width combinational adder is too large or too slow, e.g. 64-bit accumulators fed from a 16-bit datapath.
- Valid/ready handshake on both the command side and the result side.

---
 rtl/wide_add_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract controller: one shared 16-bit adder slice is stepped
// across WORDS operand words, least-significant word first. The carry is
// chained from one cycle to the next.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; start_ready high
// RUN   | one word per cycle through the slice; busy high
// DONE  | result held on sum/cout/ovf; done_valid high until done_ready
module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              op_sub,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [16*WORDS-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [WORDS-1:0][15:0]   a_q;
    logic [WORDS-1:0][15:0]   b_q;
    logic [WORDS-1:0][15:0]   sum_q;
    logic                     op_sub_q;
    logic                     carry;
    logic [IW-1:0]            idx;
    logic                     cout_q;
    logic                     ovf_q;

    logic [15:0]              a_word;
    logic [15:0]              b_word;
    logic [15:0]              s;
    logic                     c;

    // Shared slice: current word of A plus (possibly inverted) word of B plus carry.
    always_comb begin
        a_word = a_q[idx];
        b_word = op_sub_q ? ~b_q[idx] : b_q[idx];
        {c, s} = {1'b0, a_word} + {1'b0, b_word} + {16'd0, carry};
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done_valid  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            op_sub_q    <= 1'b0;
            carry       <= 1'b0;
            idx         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        a_q         <= a;
                        b_q         <= b;
                        op_sub_q    <= op_sub;
                        // Subtract is a + ~b + 1, so the external carry-in is ignored.
                        carry       <= op_sub ? 1'b1 : cin;
                        idx         <= '0;
                        state       <= RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[idx] <= s;
                    carry      <= c;
                    if (idx == LAST) begin
                        cout_q     <= c;
                        // Overflow: operands agree in sign but the result does not.
                        ovf_q      <= (a_word[15] == b_word[15]) && (s[15] != a_word[15]);
                        idx        <= '0;
                        state      <= DONE;
                        busy       <= 1'b0;
                        done_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (done_valid && done_ready) begin
                        state       <= IDLE;
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    busy        <= 1'b0;
                    done_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
